// File: rtl/usb_daq_pkg.sv
// Shared definitions for the USB DAQ scan scheduler: FSM states and frame layout.
package usb_daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_SETTLE,
    ST_CONVERT,
    ST_SEND
  } state_t;

  localparam logic [3:0]  FRAME_HDR = 4'hA;
  localparam int unsigned FRAME_LEN = 5;

  // Byte idx of a frame: header, then A and B samples, high byte first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [2:0]  ch,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [7:0] r;
    case (idx)
      3'd0:    r = {FRAME_HDR, 1'b0, ch};
      3'd1:    r = a[15:8];
      3'd2:    r = a[7:0];
      3'd3:    r = b[15:8];
      default: r = b[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usb_daq_tick_gen.sv
// Sample-tick generator: free-running period counter gated by en, period reloaded on wrap.
module usb_daq_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] rate,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] cnt_max;
  logic [15:0] reload;

  // rate 0 and 1 both collapse to a tick every cycle
  always_comb begin
    reload = (rate > 16'd1) ? (rate - 16'd1) : '0;
  end

  always_comb begin
    tick = en && (cnt == cnt_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cnt_max <= '0;
    end else if (!en) begin
      cnt     <= '0;
      cnt_max <= reload;
    end else if (cnt == cnt_max) begin
      cnt     <= '0;
      cnt_max <= reload;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/usb_daq_scan_sched.sv
// Scan scheduler: steps the analog mux, starts ADC conversions on sample ticks and
// streams each result as a 5-byte frame into the USB FIFO.
module usb_daq_scan_sched
  import usb_daq_pkg::*;
#(
  parameter int unsigned CH_NUM = 8,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned TMO    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] rate,
  output logic [2:0]  mux_addr,
  output logic        ad_go,
  input  logic        ad_done,
  input  logic [15:0] dataa,
  input  logic [15:0] datab,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        busy,
  output logic        ovf,
  output logic        tmo_err
);

  localparam int unsigned SETTLE_C    = (SETTLE < 1) ? 1 : SETTLE;
  localparam int unsigned TMO_C       = (TMO < 1) ? 1 : TMO;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_C - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TMO_C - 1);
  localparam logic [2:0]  CH_LAST     = 3'(CH_NUM - 1);
  localparam logic [2:0]  BIDX_LAST   = 3'(FRAME_LEN - 1);

  state_t      state, state_nx;
  logic        tick;
  logic [15:0] settle_cnt;
  logic [15:0] tmo_cnt;
  logic [2:0]  byte_idx;
  logic [15:0] cap_a, cap_b;
  logic        settle_last, conv_tmo, frame_done, ch_step;

  usb_daq_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .rate  (rate),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    settle_last = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
    conv_tmo    = (state == ST_CONVERT) && !ad_done && (tmo_cnt == TMO_LAST);
    frame_done  = fifo_wr && (byte_idx == BIDX_LAST);
    ch_step     = conv_tmo || frame_done;
    state_nx    = state;
    case (state)
      ST_IDLE:      if (en) state_nx = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!en)       state_nx = ST_IDLE;
        else if (tick) state_nx = ST_SETTLE;
      end
      ST_SETTLE:    if (settle_last) state_nx = ST_CONVERT;
      ST_CONVERT: begin
        if (ad_done)       state_nx = ST_SEND;
        else if (conv_tmo) state_nx = en ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_SEND:      if (frame_done) state_nx = en ? ST_WAIT_TICK : ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE) && (state != ST_WAIT_TICK);
    ad_go    = settle_last;
    fifo_wr  = (state == ST_SEND) && !fifo_full;
    fifo_din = (state == ST_SEND) ? frame_byte(byte_idx, mux_addr, cap_a, cap_b) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_addr   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      byte_idx   <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      ovf        <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      settle_cnt <= (state == ST_SETTLE)  ? (settle_cnt + 16'd1) : '0;
      tmo_cnt    <= (state == ST_CONVERT) ? (tmo_cnt + 16'd1)    : '0;
      if (state == ST_IDLE && en) begin
        ovf     <= 1'b0;
        tmo_err <= 1'b0;
      end else begin
        if (tick && busy) ovf <= 1'b1;
        if (conv_tmo)     tmo_err <= 1'b1;
      end
      if (state == ST_CONVERT && ad_done) begin
        cap_a <= dataa;
        cap_b <= datab;
      end
      if (fifo_wr) byte_idx <= (byte_idx == BIDX_LAST) ? '0 : (byte_idx + 3'd1);
      // leaving for IDLE always parks the mux on channel 0
      if (ch_step || (state_nx == ST_IDLE && state != ST_IDLE)) begin
        if (state_nx == ST_IDLE)    mux_addr <= '0;
        else if (mux_addr == CH_LAST) mux_addr <= '0;
        else                        mux_addr <= mux_addr + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_daq_scan_sched.sv
// Scoreboard bench for usb_daq_scan_sched with a behavioural ADC and FIFO back-pressure.
module tb_usb_daq_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rate = 16'd100;
  logic [2:0]  mux_addr;
  logic        ad_go;
  logic        ad_done = 1'b0;
  logic [15:0] dataa = 16'h5A5A;
  logic [15:0] datab = 16'hA5A5;
  logic [7:0]  fifo_din;
  logic        fifo_wr;
  logic        fifo_full = 1'b0;
  logic        busy, ovf, tmo_err;

  always #5 clk = ~clk;

  usb_daq_scan_sched #(.CH_NUM(8), .SETTLE(4), .TMO(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rate      (rate),
    .mux_addr  (mux_addr),
    .ad_go     (ad_go),
    .ad_done   (ad_done),
    .dataa     (dataa),
    .datab     (datab),
    .fifo_din  (fifo_din),
    .fifo_wr   (fifo_wr),
    .fifo_full (fifo_full),
    .busy      (busy),
    .ovf       (ovf),
    .tmo_err   (tmo_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int go_cnt = 0, byte_cnt = 0, cyc = 0, last_go = -1;
  int adc_left = 0, adc_delay = 20, stall_left = 0, wpos = 0, exp_ch = 0;
  bit adc_pending = 0, adc_mute = 0, chk_period = 0, stall_arm = 0;

  // ADC model, FIFO back-pressure and output monitor; inputs change on the falling edge
  always begin
    @(negedge clk);
    cyc++;
    ad_done = 1'b0;
    if (adc_pending) begin
      adc_left--;
      if (adc_left == 0) begin
        ad_done = 1'b1;
        adc_pending = 0;
      end
    end
    fifo_full = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      adc_pending = 0;
      ad_done = 1'b0;
      stall_left = 0;
      wpos = 0;
      exp_ch = 0;
      last_go = -1;
    end else begin
      if (ad_go) begin
        go_cnt++;
        check("mux_at_go", 32'(mux_addr), exp_ch);
        if (chk_period && last_go >= 0) check("go_period", cyc - last_go, 32'(rate));
        last_go = cyc;
        if (!adc_mute) begin
          exp_q.push_back({4'hA, 1'b0, 3'(exp_ch)});
          exp_q.push_back(dataa[15:8]);
          exp_q.push_back(dataa[7:0]);
          exp_q.push_back(datab[15:8]);
          exp_q.push_back(datab[7:0]);
          adc_pending = 1;
          adc_left = adc_delay;
        end
        exp_ch = (exp_ch + 1) % 8;
      end
      if (fifo_full) begin
        check("wr_while_full", 32'(fifo_wr), 0);
        if (exp_q.size() > 0) check("hold_din", 32'(fifo_din), 32'(exp_q[0]));
      end
      if (fifo_wr) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(fifo_wr), 0);
        else check("byte", 32'(fifo_din), 32'(exp_q.pop_front()));
        byte_cnt++;
        if (stall_arm && wpos == 0) begin
          stall_arm = 0;
          stall_left = 7;
        end
        wpos = (wpos + 1) % 5;
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int k = 0;
    while (byte_cnt < target && k < budget) begin
      tick_wait(1);
      k++;
    end
    if (byte_cnt < target) check("bytes_timeout", byte_cnt, target);
  endtask

  task automatic wait_go(input int target, input int budget);
    int k = 0;
    while (go_cnt < target && k < budget) begin
      tick_wait(1);
      k++;
    end
    if (go_cnt < target) check("go_timeout", go_cnt, target);
  endtask

  task automatic stop_and_idle(input int budget);
    int k = 0;
    en = 1'b0;
    while (busy && k < budget) begin
      tick_wait(1);
      k++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
    tick_wait(3);
    check("idle_mux", 32'(mux_addr), 0);
    check("idle_busy", 32'(busy), 0);
    check("q_drained", exp_q.size(), 0);
    exp_ch = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mux"}, 32'(mux_addr), 0);
    check({tag, "_go"}, 32'(ad_go), 0);
    check({tag, "_wr"}, 32'(fifo_wr), 0);
    check({tag, "_din"}, 32'(fifo_din), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_tmo"}, 32'(tmo_err), 0);
  endtask

  initial begin
    int b0, g0;
    tick_wait(2);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick_wait(2);

    // nominal scan across all channels and back to channel 0
    rate = 16'd100; adc_delay = 20; chk_period = 1; en = 1'b1;
    wait_bytes(45, 2500);
    chk_period = 0;
    check("t1_ovf", 32'(ovf), 0);
    check("t1_tmo", 32'(tmo_err), 0);
    stop_and_idle(200);

    // FIFO full for 7 cycles on the second byte of the first frame
    stall_arm = 1; b0 = byte_cnt; en = 1'b1;
    wait_bytes(b0 + 10, 600);
    stop_and_idle(200);
    check("t2_bytes", byte_cnt - b0, 10);

    // ticks faster than a frame: overflow, still one frame per ad_go
    rate = 16'd10; adc_delay = 30; dataa = 16'h1234; datab = 16'hBEEF;
    g0 = go_cnt; b0 = byte_cnt; en = 1'b1;
    wait_bytes(b0 + 15, 1000);
    check("t3_ovf", 32'(ovf), 1);
    stop_and_idle(200);
    check("t3_frame_per_go", byte_cnt - b0, (go_cnt - g0) * 5);

    // conversion timeout, then reset in the middle of the following conversion
    rate = 16'd300; adc_delay = 20; dataa = 16'hC3E1; datab = 16'h0F96; adc_mute = 1;
    g0 = go_cnt; b0 = byte_cnt; en = 1'b1;
    tick_wait(3);
    check("t4_ovf_cleared", 32'(ovf), 0);
    wait_go(g0 + 1, 600);
    tick_wait(255);
    check("t4_tmo_early", 32'(tmo_err), 0);
    tick_wait(1);
    check("t4_tmo_set", 32'(tmo_err), 1);
    check("t4_mux_adv", 32'(mux_addr), 1);
    check("t4_no_bytes", byte_cnt - b0, 0);
    check("t4_busy", 32'(busy), 0);
    adc_mute = 0;
    wait_go(g0 + 2, 600);
    tick_wait(5);
    check("t4_in_convert", 32'(busy), 1);
    rst_n = 1'b0; en = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick_wait(2);
    rst_n = 1'b1;
    b0 = byte_cnt; g0 = go_cnt;
    tick_wait(60);
    check("t4_rst_no_bytes", byte_cnt - b0, 0);
    check("t4_rst_no_go", go_cnt - g0, 0);

    // en dropped while byte 3 is on the bus: the frame still completes
    rate = 16'd100; dataa = 16'h8001; datab = 16'h7FFE; exp_ch = 0;
    b0 = byte_cnt; en = 1'b1;
    wait_bytes(b0 + 2, 400);
    en = 1'b0;
    stop_and_idle(200);
    check("t5_frame_done", byte_cnt - b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
